bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_if.sv | 34 +++
 rtl/bin_to_bcd_seq.sv | 142 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_if.sv
// Start/done handshake bundle between the controller and bin_to_bcd_seq.
// master drives start/bin_in; slave returns busy/done/bcd_out/overflow (+seg_out).
interface bin_to_bcd_seq_if #(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [IN_W-1:0]       bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef BCD_SEG_OUT_EN
  logic [7*DIGITS-1:0]   seg_out;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, seg_out
  );
  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, seg_out
  );
`else
  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );
  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary->BCD, one bit per clock (clk, rst_n, bus).
// Optional BCD_SEG_OUT_EN adds registered active-low 7-seg outputs per digit.
module bin_to_bcd_seq #(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  bin_to_bcd_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [IN_W-1:0] sr;
  logic [BW-1:0]   dig;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   dig_n;
  logic            ovf;
  logic            ovf_n;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcd_q;
  logic            ovf_q;
  logic            busy;
  logic            done;
  logic            take;
  logic            load;

  always_comb begin
    adj = dig;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig[4*k+:4] >= 4'd5)
        adj[4*k+:4] = dig[4*k+:4] + 4'd3;
    end
  end

  // Bit leaving the top digit means value >= 10^DIGITS; keep it sticky.
  assign dig_n = {adj[BW-2:0], sr[IN_W-1]};
  assign ovf_n = ovf | adj[BW-1];

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    take    = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          take    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          load    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef BCD_SEG_OUT_EN
  logic [7*DIGITS-1:0] seg_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '1;
    end else if (load) begin
      for (int k = 0; k < DIGITS; k++)
        seg_q[7*k+:7] <= seg7(dig_n[4*k+:4]);
    end
  end

  assign bus.seg_out = seg_q;
`endif

  // Results are loaded on the final shift edge so they are already
  // visible during the DONE cycle, together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      dig   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        sr  <= bus.bin_in;
        dig <= '0;
        ovf <= 1'b0;
        cnt <= CW'(IN_W);
      end else if (busy) begin
        sr  <= sr << 1;
        dig <= dig_n;
        ovf <= ovf_n;
        cnt <= cnt - CW'(1);
      end
      if (load) begin
        bcd_q <= dig_n;
        ovf_q <= ovf_n;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: DIGITS=3 and DIGITS=2 instances fed the
// same stimulus; queued expectations are checked on every done pulse.
module tb_bin_to_bcd_seq;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] bin_in;
  int         cyc;
  int         checks;
  int         errors;

  typedef struct {
    logic [11:0] b3;
    logic        o3;
    logic [7:0]  b2;
    logic        o2;
  } exp_t;

  typedef struct {
    logic [8:0] v;
    exp_t       e;
  } vec_t;

  exp_t q3[$];
  exp_t q2[$];

  bin_to_bcd_seq_if #(.IN_W(9), .DIGITS(3)) b3 ();
  bin_to_bcd_seq_if #(.IN_W(9), .DIGITS(2)) b2 ();

  assign b3.start  = start;
  assign b3.bin_in = bin_in;
  assign b2.start  = start;
  assign b2.bin_in = bin_in;

  bin_to_bcd_seq #(.IN_W(9), .DIGITS(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );
  bin_to_bcd_seq #(.IN_W(9), .DIGITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, r);
    end
  endtask

  function automatic logic [6:0] segx(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000};
    return (d < 10) ? t[d] : 7'b1111111;
  endfunction

  always @(negedge clk) begin
    if (rst_n && b3.done) begin
      if (q3.size() == 0) begin
        chk("d3_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("d3_bcd", b3.bcd_out, e.b3);
        chk("d3_ovf", b3.overflow, e.o3);
`ifdef BCD_SEG_OUT_EN
        chk("d3_seg", b3.seg_out,
            {segx(e.b3[11:8]), segx(e.b3[7:4]), segx(e.b3[3:0])});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b2.done) begin
      if (q2.size() == 0) begin
        chk("d2_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("d2_bcd", b2.bcd_out, e.b2);
        chk("d2_ovf", b2.overflow, e.o2);
      end
    end
  end

  task automatic push(input exp_t e);
    q3.push_back(e);
    q2.push_back(e);
  endtask

  // Starts one conversion from IDLE and waits for done (bounded).
  task automatic run(input vec_t t);
    int acc;
    bit got;
    push(t.e);
    @(negedge clk);
    start  = 1'b1;
    bin_in = t.v;
    @(negedge clk);
    start = 1'b0;
    acc   = cyc;
    got   = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b3.done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("done_latency", cyc + 1 - acc, 10);
  endtask

  vec_t tab[8];

  initial begin
    int ndone;
    int last;
    int busy_n;
    int dt[$];

    tab[0] = '{9'd255, '{12'h255, 1'b0, 8'h55, 1'b1}};
    tab[1] = '{9'd0,   '{12'h000, 1'b0, 8'h00, 1'b0}};
    tab[2] = '{9'd511, '{12'h511, 1'b0, 8'h11, 1'b1}};
    tab[3] = '{9'd100, '{12'h100, 1'b0, 8'h00, 1'b1}};
    tab[4] = '{9'd99,  '{12'h099, 1'b0, 8'h99, 1'b0}};
    tab[5] = '{9'd1,   '{12'h001, 1'b0, 8'h01, 1'b0}};
    tab[6] = '{9'd300, '{12'h300, 1'b0, 8'h00, 1'b1}};
    tab[7] = '{9'd42,  '{12'h042, 1'b0, 8'h42, 1'b0}};

    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", b3.busy, 0);
    chk("rst_done", b3.done, 0);
    chk("rst_bcd", b3.bcd_out, 0);
    chk("rst_ovf", b3.overflow, 0);
    chk("rst_bcd2", b2.bcd_out, 0);
`ifdef BCD_SEG_OUT_EN
    chk("rst_seg", b3.seg_out, 21'h1FFFFF);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run(tab[i]);

    // start with 7 asserted mid-conversion of 100 must be ignored.
    push('{12'h100, 1'b0, 8'h00, 1'b1});
    @(negedge clk);
    start  = 1'b1;
    bin_in = 9'd100;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) begin
        start  = 1'b1;
        bin_in = 9'd7;
        chk("hold_bcd", b3.bcd_out, 12'h042);
      end
      if (i == 5) start = 1'b0;
      @(negedge clk);
      if (b3.done) ndone++;
    end
    chk("ignored_start_dones", ndone, 1);
    run('{9'd7, '{12'h007, 1'b0, 8'h07, 1'b0}});

    // Async reset mid-conversion of 300.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 9'd300;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", b3.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", b3.bcd_out, 0);
    chk("abort_busy", b3.busy, 0);
    chk("abort_ovf", b2.overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run('{9'd42, '{12'h042, 1'b0, 8'h42, 1'b0}});

    // start held high: back-to-back conversions every 11 cycles.
    for (int i = 0; i < 3; i++) push('{12'h037, 1'b0, 8'h37, 1'b0});
    @(negedge clk);
    start  = 1'b1;
    bin_in = 9'd37;
    busy_n = 0;
    last   = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 29) start = 1'b0;
      if (b3.busy) busy_n++;
      if (b3.done) begin
        if (last >= 0) dt.push_back(cyc - last);
        last = cyc;
      end
    end
    chk("b2b_gaps", dt.size(), 2);
    foreach (dt[k]) chk("b2b_period", dt[k], 11);
    chk("b2b_busy_cycles", busy_n, 27);
    chk("q3_drained", q3.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
